// File: rtl/uart_tx_feeder.sv
// Byte FIFO plus launch sequencer feeding a UART transmitter: pop, set up t_DATA, pulse trig_ss, wait tx_done, hold gap.
// Optional even-parity output t_PARITY is built when UART_TX_FEEDER_PARITY_EN is defined.
module uart_tx_feeder #(
    parameter int DEPTH      = 8,
    parameter int ADDR_W     = 3,
    parameter int GAP_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [7:0]        wr_data,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic [7:0]        t_DATA,
`ifdef UART_TX_FEEDER_PARITY_EN
    output logic              t_PARITY,
`endif
    output logic              trig_ss,
    input  logic              tx_busy,
    input  logic              tx_done
);

    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    typedef enum logic [2:0] {IDLE, LOAD, TRIG, WAIT, GAP} state_t;

    state_t            state;
    logic [GW-1:0]     gap_cnt;
    logic [7:0]        mem [DEPTH];
    logic [ADDR_W:0]   wptr, rptr, wptr_nx, rptr_nx, count_nx;
    logic              push, pop;

    assign push     = wr_en && !full;
    assign pop      = (state == IDLE) && !empty && !tx_busy;
    assign wptr_nx  = push ? wptr + 1'b1 : wptr;
    assign rptr_nx  = pop  ? rptr + 1'b1 : rptr;
    assign count_nx = wptr_nx - rptr_nx;

    always_ff @(posedge clk) begin
        if (push) mem[wptr[ADDR_W-1:0]] <= wr_data;
    end

    // Flags are computed from next-state pointers so they stay in lockstep with them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
            overflow <= 1'b0;
        end else begin
            wptr     <= wptr_nx;
            rptr     <= rptr_nx;
            count    <= count_nx;
            full     <= (count_nx == (ADDR_W+1)'(DEPTH));
            empty    <= (wptr_nx == rptr_nx);
            overflow <= wr_en && full;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            gap_cnt  <= '0;
            t_DATA   <= 8'h00;
            trig_ss  <= 1'b0;
`ifdef UART_TX_FEEDER_PARITY_EN
            t_PARITY <= 1'b0;
`endif
        end else begin
            trig_ss <= 1'b0;
            case (state)
                IDLE: if (pop) begin
                    t_DATA   <= mem[rptr[ADDR_W-1:0]];
`ifdef UART_TX_FEEDER_PARITY_EN
                    t_PARITY <= ^mem[rptr[ADDR_W-1:0]];
`endif
                    state    <= LOAD;
                end
                LOAD: begin
                    trig_ss <= 1'b1;
                    state   <= TRIG;
                end
                TRIG: state <= WAIT;
                WAIT: if (tx_done) begin
                    if (GAP_CYCLES == 0) begin
                        state <= IDLE;
                    end else begin
                        gap_cnt <= GW'(GAP_CYCLES - 1);
                        state   <= GAP;
                    end
                end
                GAP: begin
                    if (gap_cnt == '0) state <= IDLE;
                    else               gap_cnt <= gap_cnt - 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Self-checking bench for uart_tx_feeder: vector table, transmitter model with byte scoreboard, reset and zero-gap sequences.
module tb_uart_tx_feeder;

    localparam int DEPTH = 8;
    localparam int ADDR_W = 3;
    localparam int GAP = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic wr_en = 1'b0, tx_busy = 1'b0, tx_done = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic full, empty, overflow, trig_ss;
    logic [ADDR_W:0] count;
    logic [7:0] t_DATA;

    logic g0_we = 1'b0, g0_done = 1'b0;
    logic [7:0] g0_wd = 8'h00;
    logic g0_full, g0_empty, g0_ovf, g0_trig;
    logic [ADDR_W:0] g0_count;
    logic [7:0] g0_data;
`ifdef UART_TX_FEEDER_PARITY_EN
    logic t_PARITY, g0_par;
`endif

    uart_tx_feeder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .GAP_CYCLES(GAP)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data),
        .full(full), .empty(empty), .count(count), .overflow(overflow),
        .t_DATA(t_DATA),
`ifdef UART_TX_FEEDER_PARITY_EN
        .t_PARITY(t_PARITY),
`endif
        .trig_ss(trig_ss), .tx_busy(tx_busy), .tx_done(tx_done));

    uart_tx_feeder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .GAP_CYCLES(0)) dut_g0 (
        .clk(clk), .rst_n(rst_n), .wr_en(g0_we), .wr_data(g0_wd),
        .full(g0_full), .empty(g0_empty), .count(g0_count), .overflow(g0_ovf),
        .t_DATA(g0_data),
`ifdef UART_TX_FEEDER_PARITY_EN
        .t_PARITY(g0_par),
`endif
        .trig_ss(g0_trig), .tx_busy(1'b0), .tx_done(g0_done));

    int pass_cnt = 0, total_cnt = 0, cyc = 0;

    // Transmitter / scoreboard model state
    bit auto_tx = 0;
    int fixed_len = 0;
    logic [7:0] exp_q[$];
    bit busy_m = 0;
    int tx_left = 0;
    logic [7:0] cur_byte = 8'h00;
    int gap_at = -1;
    logic prev_trig = 1'b0;
    int trig_cnt = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h, want %0h (cycle %0d)", nm, act, exp, cyc);
    endtask

    task automatic step(input logic we, input logic [7:0] wd, input logic bz, input logic dn);
        logic [7:0] e;
        @(negedge clk);
        cyc++;
        if (auto_tx) begin
            chk("no_overflow", overflow, 1'b0);
            if (trig_ss) begin
                trig_cnt++;
                chk("trig_width", prev_trig, 1'b0);
                chk("queue_has_byte", exp_q.size() > 0, 1'b1);
                e = t_DATA;
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("t_DATA", t_DATA, e);
`ifdef UART_TX_FEEDER_PARITY_EN
                    chk("t_PARITY", t_PARITY, ^e);
`endif
                end
                cur_byte = e;
                busy_m = 1;
                tx_left = (fixed_len > 0) ? fixed_len : int'($urandom_range(25, 5));
            end else if (busy_m) begin
                chk("t_DATA_hold", t_DATA, cur_byte);
            end
            if (gap_at == cyc) begin
                chk("gap_timing", trig_ss, 1'b1);
                gap_at = -1;
            end
            prev_trig = trig_ss;
            tx_done = 1'b0;
            if (busy_m && !trig_ss) begin
                tx_left--;
                if (tx_left == 0) begin
                    tx_done = 1'b1;
                    busy_m = 0;
                end
            end
            tx_busy = busy_m;
            if (we) exp_q.push_back(wd);
            if (tx_done && exp_q.size() > 0) gap_at = cyc + GAP + 3;
        end else begin
            tx_busy = bz;
            tx_done = dn;
        end
        wr_en = we;
        wr_data = wd;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((exp_q.size() > 0 || busy_m || gap_at >= 0) && n < budget) begin
            step(1'b0, 8'h00, 1'b0, 1'b0);
            n++;
        end
        chk("drain_in_budget", n < budget, 1'b1);
    endtask

    typedef struct {
        logic we; logic [7:0] wd; logic bz; logic dn;
        logic e_trig; logic [7:0] e_data; logic e_empty; logic e_full;
        logic [ADDR_W:0] e_count; logic e_ovf;
    } vec_t;

    typedef struct {
        logic we; logic [7:0] wd; logic dn;
        logic e_trig; logic [7:0] e_data; logic chk_data;
    } g0_t;

    function automatic vec_t mk(logic we, logic [7:0] wd, logic bz, logic dn, logic tr,
                                logic [7:0] d, logic em, logic fu, logic [ADDR_W:0] c, logic ov);
        vec_t v;
        v.we = we; v.wd = wd; v.bz = bz; v.dn = dn; v.e_trig = tr; v.e_data = d;
        v.e_empty = em; v.e_full = fu; v.e_count = c; v.e_ovf = ov;
        return v;
    endfunction

    function automatic g0_t mk0(logic we, logic [7:0] wd, logic dn, logic tr, logic [7:0] d);
        g0_t v;
        v.we = we; v.wd = wd; v.dn = dn; v.e_trig = tr; v.e_data = d; v.chk_data = tr;
        return v;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t tbl[$];
        g0_t t0[$];
        int n;

        // single launch, gap, tx_done ignored outside WAIT
        tbl.push_back(mk(1, 8'h0A, 0, 0, 0, 8'h00, 0, 0, 1, 0));
        tbl.push_back(mk(0, 8'h00, 0, 0, 0, 8'h0A, 1, 0, 0, 0));
        tbl.push_back(mk(0, 8'h00, 0, 0, 1, 8'h0A, 1, 0, 0, 0));
        tbl.push_back(mk(0, 8'h00, 0, 0, 0, 8'h0A, 1, 0, 0, 0));
        tbl.push_back(mk(0, 8'h00, 1, 0, 0, 8'h0A, 1, 0, 0, 0));
        tbl.push_back(mk(0, 8'h00, 0, 1, 0, 8'h0A, 1, 0, 0, 0));
        tbl.push_back(mk(0, 8'h00, 0, 0, 0, 8'h0A, 1, 0, 0, 0));
        tbl.push_back(mk(0, 8'h00, 0, 1, 0, 8'h0A, 1, 0, 0, 0));
        tbl.push_back(mk(0, 8'h00, 0, 0, 0, 8'h0A, 1, 0, 0, 0));
        // fill with transmitter busy: 8 accepted, 9th dropped
        for (int k = 0; k < 9; k++)
            tbl.push_back(mk(1, 8'h40 + 8'(k), 1, 0, 0, 8'h0A, 0, k >= 7,
                             (ADDR_W+1)'((k < 8) ? k + 1 : 8), k == 8));
        for (int k = 0; k < 3; k++)
            tbl.push_back(mk(0, 8'h00, 1, 0, 0, 8'h0A, 0, 1, 4'd8, 0));

        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_full", full, 1'b0);
        chk("rst_empty", empty, 1'b1);
        chk("rst_count", count, 0);
        chk("rst_overflow", overflow, 1'b0);
        chk("rst_t_DATA", t_DATA, 8'h00);
        chk("rst_trig_ss", trig_ss, 1'b0);
`ifdef UART_TX_FEEDER_PARITY_EN
        chk("rst_t_PARITY", t_PARITY, 1'b0);
`endif
        rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].we, tbl[i].wd, tbl[i].bz, tbl[i].dn);
            @(posedge clk); #1;
            chk($sformatf("tbl%0d_trig", i), trig_ss, tbl[i].e_trig);
            chk($sformatf("tbl%0d_data", i), t_DATA, tbl[i].e_data);
            chk($sformatf("tbl%0d_empty", i), empty, tbl[i].e_empty);
            chk($sformatf("tbl%0d_full", i), full, tbl[i].e_full);
            chk($sformatf("tbl%0d_count", i), count, tbl[i].e_count);
            chk($sformatf("tbl%0d_ovf", i), overflow, tbl[i].e_ovf);
        end

        // release the stall; the eight accepted bytes come out in order, the dropped one never
        auto_tx = 1;
        busy_m = 0;
        prev_trig = 1'b0;
        for (int k = 0; k < 8; k++) exp_q.push_back(8'h40 + 8'(k));
        drain(2000);
        repeat (10) step(1'b0, 8'h00, 1'b0, 1'b0);
        chk("post_fill_empty", empty, 1'b1);

        // back-to-back frames with a fixed-length transmitter
        fixed_len = 20;
        step(1'b1, 8'h11, 1'b0, 1'b0);
        step(1'b1, 8'h22, 1'b0, 1'b0);
        step(1'b1, 8'h33, 1'b0, 1'b0);
        drain(2000);

        // random bursts against the scoreboard
        fixed_len = 0;
        for (int i = 0; i < 400; i++)
            step(($urandom_range(0, 3) == 0) && (exp_q.size() < DEPTH), 8'($urandom), 1'b0, 1'b0);
        drain(3000);
        repeat (8) step(1'b0, 8'h00, 1'b0, 1'b0);
        chk("rand_end_empty", empty, 1'b1);
        chk("rand_end_count", count, 0);

        // asynchronous reset in the middle of a frame with bytes still queued
        fixed_len = 20;
        for (int k = 0; k < 5; k++) step(1'b1, 8'hA0 + 8'(k), 1'b0, 1'b0);
        n = 0;
        while (!(busy_m && exp_q.size() == 4) && n < 100) begin
            step(1'b0, 8'h00, 1'b0, 1'b0);
            n++;
        end
        chk("reached_wait", n < 100, 1'b1);
        repeat (3) step(1'b0, 8'h00, 1'b0, 1'b0);
        chk("pre_rst_count", count, 4);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_trig_ss", trig_ss, 1'b0);
        chk("arst_t_DATA", t_DATA, 8'h00);
        chk("arst_count", count, 0);
        chk("arst_empty", empty, 1'b1);
        chk("arst_full", full, 1'b0);
        exp_q.delete();
        busy_m = 0; gap_at = -1; tx_done = 1'b0; tx_busy = 1'b0; wr_en = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        trig_cnt = 0;
        repeat (15) step(1'b0, 8'h00, 1'b0, 1'b0);
        chk("no_launch_after_rst", trig_cnt, 0);
        chk("post_rst_empty", empty, 1'b1);
        step(1'b1, 8'h5C, 1'b0, 1'b0);
        drain(200);
        chk("relaunch_count", trig_cnt, 1);
        auto_tx = 0;
        tx_busy = 1'b0;
        tx_done = 1'b0;

        // zero-gap instance: 3-cycle relaunch and stray tx_done outside WAIT
        t0.push_back(mk0(1, 8'h77, 0, 0, 8'h00));
        t0.push_back(mk0(0, 8'h00, 0, 0, 8'h00));
        t0.push_back(mk0(0, 8'h00, 0, 0, 8'h00));
        t0.push_back(mk0(0, 8'h00, 0, 1, 8'h77));
        t0.push_back(mk0(1, 8'h78, 0, 0, 8'h00));
        t0.push_back(mk0(0, 8'h00, 1, 0, 8'h00));
        t0.push_back(mk0(0, 8'h00, 0, 0, 8'h00));
        t0.push_back(mk0(0, 8'h00, 0, 0, 8'h00));
        t0.push_back(mk0(0, 8'h00, 0, 1, 8'h78));
        t0.push_back(mk0(0, 8'h00, 1, 0, 8'h00));
        t0.push_back(mk0(0, 8'h00, 1, 0, 8'h00));
        t0.push_back(mk0(1, 8'h79, 0, 0, 8'h00));
        t0.push_back(mk0(0, 8'h00, 0, 0, 8'h00));
        t0.push_back(mk0(0, 8'h00, 0, 0, 8'h00));
        t0.push_back(mk0(0, 8'h00, 0, 1, 8'h79));
        t0.push_back(mk0(1, 8'h7A, 0, 0, 8'h00));
        for (int k = 0; k < 3; k++) t0.push_back(mk0(0, 8'h00, 0, 0, 8'h00));
        t0.push_back(mk0(0, 8'h00, 1, 0, 8'h00));
        t0.push_back(mk0(0, 8'h00, 0, 0, 8'h00));
        t0.push_back(mk0(0, 8'h00, 0, 0, 8'h00));
        t0.push_back(mk0(0, 8'h00, 0, 1, 8'h7A));
        t0.push_back(mk0(0, 8'h00, 0, 0, 8'h00));

        for (int i = 0; i < t0.size(); i++) begin
            @(negedge clk);
            cyc++;
            chk($sformatf("g0_%0d_trig", i), g0_trig, t0[i].e_trig);
            if (t0[i].chk_data) begin
                chk($sformatf("g0_%0d_data", i), g0_data, t0[i].e_data);
`ifdef UART_TX_FEEDER_PARITY_EN
                chk($sformatf("g0_%0d_par", i), g0_par, ^t0[i].e_data);
`endif
            end
            g0_we = t0[i].we;
            g0_wd = t0[i].wd;
            g0_done = t0[i].dn;
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
